// File: rtl/rpsc_pkg.sv
// Shared types and width helpers for the RPSC alarm transmitter.
// The frame widths are derived from the channel count.
package rpsc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    function automatic int unsigned fo_w(input int unsigned n_ch);
        return $clog2(n_ch);
    endfunction

    function automatic int unsigned payload_w(input int unsigned n_ch);
        return n_ch + 2 + fo_w(n_ch);
    endfunction

    function automatic int unsigned frame_w(input int unsigned n_ch);
        return payload_w(n_ch) + 3;
    endfunction

endpackage

// File: rtl/rpsc_sync.sv
// Multi-stage flop synchronizer for a bus of independent asynchronous lines.
module rpsc_sync #(
    parameter int unsigned Width  = 1,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Stages-1:0][Width-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[Stages-2:0], d_i};
        end
    end

    assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/rpsc_alarm_tx.sv
// Synchronizes latched-alarm/interlock lines, records the first-out channel and
// serializes a parity-protected status frame on a UART-style line.
module rpsc_alarm_tx
    import rpsc_pkg::*;
#(
    parameter int unsigned N_CH           = 8,
    parameter int unsigned BIT_DIV        = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         la_in,
    input  logic                    interlock_in,
    input  logic                    clr_first_out,
    output logic                    tx_out,
    output logic                    tx_busy,
    output logic                    frame_sent,
    output logic                    fo_valid,
    output logic [fo_w(N_CH)-1:0]   fo_idx
);

    localparam int unsigned FoW      = fo_w(N_CH);
    localparam int unsigned PayloadW = payload_w(N_CH);
    localparam int unsigned FrameW   = frame_w(N_CH);
    localparam int unsigned DW       = $clog2(BIT_DIV);
    localparam int unsigned BW       = $clog2(FrameW);
    localparam int unsigned RW       = $clog2(REFRESH_CYCLES + 1);
    localparam logic [DW-1:0] DivLast     = DW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BitLast     = BW'(FrameW - 1);
    localparam logic [RW-1:0] RefreshLast = RW'(REFRESH_CYCLES - 1);

    state_e state_q, state_d;

    logic [N_CH:0]     sync_s;
    logic [N_CH-1:0]   la_s, la_prev_q, rise;
    logic              il_s;
    logic [N_CH:0]     last_sent_q, last_sent_d;
    logic              pending_q, pending_d;
    logic [RW-1:0]     refresh_q, refresh_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [FrameW-1:0] shift_q, shift_d;
    logic              frame_sent_q, frame_sent_d;
    logic              fo_valid_q, fo_valid_d;
    logic [FoW-1:0]    fo_idx_q, fo_idx_d, rise_idx;
    logic [PayloadW-1:0] payload;
    logic [FrameW-1:0] frame;
    logic              diff, div_last, bit_last;

    rpsc_sync #(
        .Width  (N_CH + 1),
        .Stages (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    ({interlock_in, la_in}),
        .q_o    (sync_s)
    );

    assign la_s     = sync_s[N_CH-1:0];
    assign il_s     = sync_s[N_CH];
    assign diff     = (sync_s != last_sent_q);
    assign div_last = (div_q == DivLast);
    assign bit_last = (bit_q == BitLast);
    assign rise     = la_s & ~la_prev_q;

    // Line order is LSB first: start, la, interlock, fo_valid, fo_idx, parity, stop.
    assign payload = {fo_idx_q, fo_valid_q, il_s, la_s};
    assign frame   = {1'b1, ^payload, payload, 1'b0};

    always_comb begin
        rise_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rise[i]) rise_idx = FoW'(i);
        end
    end

    // A rise beats a simultaneous clear so the new first-out is never lost.
    always_comb begin
        fo_valid_d = fo_valid_q;
        fo_idx_d   = fo_idx_q;
        if ((|rise) && (!fo_valid_q || clr_first_out)) begin
            fo_valid_d = 1'b1;
            fo_idx_d   = rise_idx;
        end else if (clr_first_out) begin
            fo_valid_d = 1'b0;
            fo_idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pending_q) state_d = StShift;
            StShift: if (div_last && bit_last) state_d = StGap;
            StGap:   if (div_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_out  = 1'b1;
        tx_busy = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StShift: begin
                tx_out  = shift_q[0];
                tx_busy = 1'b1;
            end
            StGap:   tx_busy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        div_d        = div_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        pending_d    = pending_q;
        last_sent_d  = last_sent_q;
        refresh_d    = refresh_q;
        frame_sent_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    shift_d     = frame;
                    last_sent_d = sync_s;
                    pending_d   = 1'b0;
                    refresh_d   = '0;
                    div_d       = '0;
                    bit_d       = '0;
                end else begin
                    if (refresh_q != RefreshLast) refresh_d = refresh_q + RW'(1);
                    pending_d = diff || (refresh_d == RefreshLast);
                end
            end
            StShift: begin
                pending_d = pending_q || diff;
                if (div_last) begin
                    div_d = '0;
                    if (bit_last) begin
                        frame_sent_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = {1'b1, shift_q[FrameW-1:1]};
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            StGap: begin
                pending_d = pending_q || diff;
                div_d     = div_last ? '0 : div_q + DW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            la_prev_q    <= '0;
            last_sent_q  <= '0;
            pending_q    <= 1'b0;
            refresh_q    <= '0;
            div_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '1;
            frame_sent_q <= 1'b0;
            fo_valid_q   <= 1'b0;
            fo_idx_q     <= '0;
        end else begin
            la_prev_q    <= la_s;
            last_sent_q  <= last_sent_d;
            pending_q    <= pending_d;
            refresh_q    <= refresh_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            frame_sent_q <= frame_sent_d;
            fo_valid_q   <= fo_valid_d;
            fo_idx_q     <= fo_idx_d;
        end
    end

    assign frame_sent = frame_sent_q;
    assign fo_valid   = fo_valid_q;
    assign fo_idx     = fo_idx_q;

endmodule

// File: doc/rpsc_alarm_tx.md
Name: rpsc_alarm_tx

Overview:
Reads the latched alarm (LA) and PAMP interlock lines produced by the RPSC fault-latch cards. It synchronizes them, tracks which channel faulted first, and serializes a status frame to the remote annunciator panel over a single UART-style line. It sits on the card-cage backplane opposite the latch cards.
- Latch cards write alarm state; this block reads it and transmits it.

Parameters:
- N_CH, 8, number of LA channels
- BIT_DIV, 16, clk cycles per serial bit (>=2)
- SYNC_STAGES, 2, synchronizer depth (>=2)
- REFRESH_CYCLES, 1000000, idle cycles between forced re-sends (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- la_in  in  N_CH  asynchronous latched-alarm lines; bit i = channel i
- interlock_in  in  1  asynchronous PAMP interlock line
- clr_first_out  in  1  synchronous one-cycle pulse; clears first-out record
- tx_out  out  1  serial line; idles high
- tx_busy  out  1  high while a frame is on the line, including the inter-frame gap
- frame_sent  out  1  one-cycle pulse at the end of the stop bit
- fo_valid  out  1  first-out record holds a channel
- fo_idx  out  $clog2(N_CH)  first-out channel index

Behaviour:
- Reset values: tx_out=1, tx_busy=0, frame_sent=0, fo_valid=0, fo_idx=0. Synchronizers=0, last_sent=0, pending=0, refresh counter=0, state=IDLE.
- Reset takes effect asynchronously and is released synchronously via the deasserting edge. Reset mid-frame aborts the frame; tx_out returns high immediately.
- Input path: la_in and interlock_in each pass through SYNC_STAGES flops, giving la_s and il_s.
- First-out record:
  - Rising edge of any la_s bit while fo_valid=0 sets fo_valid=1 and fo_idx to the rising index.
  - If several bits rise in the same cycle, the lowest index wins.
  - clr_first_out clears fo_valid and fo_idx to 0.
  - If clr_first_out and a rise occur in the same cycle, the rise wins and the new index is captured.
- Frame, bit order on the line, 1 bit = BIT_DIV cycles:
  1. start bit (0)
  2. la snapshot, LSB first (N_CH bits)
  3. interlock (1)
  4. fo_valid (1)
  5. fo_idx, LSB first
  6. parity (1), even parity over all payload bits (fields 2-5)
  7. stop bit (1)
  - For N_CH=8 the frame is 16 bits.
- Snapshot rule: the payload is captured into a shift register in the cycle the start bit begins. Later input changes do not alter the frame in flight.
- Trigger rule: pending is set when {la_s, il_s} differs from last_sent, or when the refresh counter reaches REFRESH_CYCLES-1.
  - The refresh counter increments only in IDLE.
  - It clears on frame start.
- FSM:
  - IDLE: tx_busy=0. If pending, go to SHIFT next cycle, load the snapshot, set last_sent, clear pending.
  - SHIFT: bit counter and divide counter run; tx_busy=1. After the last cycle of the stop bit, pulse frame_sent and go to GAP.
  - GAP: tx_out=1 for exactly BIT_DIV cycles; tx_busy=1. Then go to IDLE.
- A change during SHIFT or GAP sets pending. The frame carrying it starts the cycle after IDLE is re-entered, so back-to-back frames are separated by exactly one bit-time plus one cycle.
- Latency: from IDLE, tx_out falls exactly SYNC_STAGES+2 cycles after an la_in edge.
- Counters wrap only by explicit reload; no counter overflows.

Decomposition:
- Package rpsc_pkg:
  - state enum (IDLE, SHIFT, GAP)
  - localparam functions for FO_W=$clog2(N_CH)
  - PAYLOAD_W=N_CH+2+FO_W
  - FRAME_W=PAYLOAD_W+3
- Sub-module rpsc_sync: parameterized width/depth synchronizer with async active-low reset. Instantiated once for {interlock_in, la_in}.

Test Plan:
All scenarios use N_CH=8, BIT_DIV=4, SYNC_STAGES=2, REFRESH_CYCLES=200.
1. Reset, then la_in 0x00->0x05, interlock=0 -> fo_valid=1, fo_idx=0.
   - tx_out falls 4 cycles after the edge.
   - Frame bits: 0, 1,0,1,0,0,0,0,0, 0, 1, 0,0,0, 1, 1.
   - frame_sent pulses once after 64 cycles.
2. la_in 0x00->0x30 in one cycle -> fo_idx=4.
   - Then la_in |= 0x01 -> fo_idx stays 4, and a second frame is sent with data 0x31.
3. clr_first_out coinciding with the la_s rise of bit 6 (la_in 0x00->0x40) -> fo_valid=1, fo_idx=6.
4. Change la_in 0x00->0x02 mid-frame at bit 5 -> the in-flight frame keeps its snapshot.
   - A second frame starts exactly 5 cycles after the first frame_sent, carrying 0x02.
5. Stable inputs -> a refresh frame starts 200 IDLE cycles after the previous GAP ends, repeating indefinitely.
6. Assert reset at bit 9 of a frame -> tx_out=1 and tx_busy=0 asynchronously.
   - After release, la_in 0x05 (held) triggers a fresh frame.
